// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the parametrised serial pattern detector.
package seq_detect_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HUNT = 1'b1
  } state_e;

  localparam logic [31:0] DEF_PAT = 32'b1001;
  localparam int          DEF_LEN = 4;

  // Width needed to hold a pattern length of 0..max_len.
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_window.sv
// Serial shift window with a length-masked compare against the programmed pattern.
module seq_window #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shift_en,
  input  logic               clear,
  input  logic               data_in,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [LEN_W-1:0]   len,
  output logic               match_raw
);

  // The incoming bit completes the window, so only MAX_LEN-1 history bits are kept.
  logic [MAX_LEN-2:0] win_q, win_d;
  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] mask;

  always_comb begin
    cand  = {win_q, data_in};
    win_d = win_q;
    if (clear) begin
      win_d = '0;
    end else if (shift_en) begin
      win_d = cand[MAX_LEN-2:0];
    end
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
    match_raw = (((cand ^ pat) & mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q <= '0;
    end else begin
      win_q <= win_d;
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Programmable serial pattern detector with overlap control.
// Optional saturating match counter enabled by defining SEQ_DET_CNT_EN.
//
//   state   | meaning
//   ST_FILL | fewer than len valid bits held since reset/load/restart
//   ST_HUNT | window full, compare on every valid bit
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int                 MAX_LEN = 8,
  parameter logic [MAX_LEN-1:0] RST_PAT = DEF_PAT[MAX_LEN-1:0],
  parameter int                 RST_LEN = DEF_LEN,
  parameter int                 CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       data_in,
  input  logic                       din_vld,
  input  logic                       cfg_load,
  input  logic [MAX_LEN-1:0]         cfg_pat,
  input  logic [len_w(MAX_LEN)-1:0]  cfg_len,
  input  logic                       overlap,
  output logic                       data_out,
  output logic                       busy
`ifdef SEQ_DET_CNT_EN
  ,
  output logic [CNT_W-1:0]           match_cnt
`endif
);

  localparam int LEN_W = len_w(MAX_LEN);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic               data_out_q, data_out_d;
  logic [LEN_W-1:0]   len_clamp;
  logic               shift_en;
  logic               full;
  logic               match_raw;
  logic               match;

  seq_window #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_window (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (shift_en),
    .clear     (cfg_load),
    .data_in   (data_in),
    .pat       (pat_q),
    .len       (len_q),
    .match_raw (match_raw)
  );

  always_comb begin
    len_clamp = cfg_len;
    if (cfg_len < LEN_W'(2)) begin
      len_clamp = LEN_W'(2);
    end else if (cfg_len > LEN_W'(MAX_LEN)) begin
      len_clamp = LEN_W'(MAX_LEN);
    end
  end

  // A load discards the bit presented in the same cycle.
  always_comb begin
    shift_en   = din_vld & ~cfg_load;
    full       = (fill_q >= len_q - 1'b1);
    match      = shift_en & full & match_raw;
    state_d    = state_q;
    fill_d     = fill_q;
    len_d      = len_q;
    pat_d      = pat_q;
    data_out_d = match;
    if (cfg_load) begin
      pat_d   = cfg_pat;
      len_d   = len_clamp;
      fill_d  = '0;
      state_d = ST_FILL;
    end else if (din_vld) begin
      if (match && !overlap) begin
        fill_d  = '0;
        state_d = ST_FILL;
      end else if (full) begin
        fill_d  = len_q;
        state_d = ST_HUNT;
      end else begin
        fill_d  = fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FILL;
      fill_q     <= '0;
      len_q      <= LEN_W'(RST_LEN);
      pat_q      <= RST_PAT;
      data_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      len_q      <= len_d;
      pat_q      <= pat_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;
  assign busy     = (state_q == ST_FILL);

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts on the same edge that raises data_out, so the count tracks the pulse.
  always_comb begin
    cnt_d = cnt_q;
    if (cfg_load) begin
      cnt_d = '0;
    end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param; counter checks active when SEQ_DET_CNT_EN is defined.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       data_in = 1'b0;
  logic       din_vld = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pat = '0;
  logic [3:0] cfg_len = '0;
  logic       overlap = 1'b0;
  logic       data_out;
  logic       busy;
`ifdef SEQ_DET_CNT_EN
  logic [1:0] match_cnt;
`endif

  seq_detect_param #(
    .MAX_LEN (8),
    .RST_PAT (8'b0000_1001),
    .RST_LEN (4),
    .CNT_W   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .din_vld   (din_vld),
    .cfg_load  (cfg_load),
    .cfg_pat   (cfg_pat),
    .cfg_len   (cfg_len),
    .overlap   (overlap),
    .data_out  (data_out),
    .busy      (busy)
`ifdef SEQ_DET_CNT_EN
    ,
    .match_cnt (match_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       dout;
    logic       busy;
    logic [1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t e, o;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: bits received since the last restart, newest at the back.
  bit         hist[$];
  logic [7:0] m_pat  = 8'b1001;
  int         m_len  = 4;
  bit         m_busy = 1'b1;
  int         m_cnt  = 0;

  task automatic model_step(input bit d, input bit v, input bit ld, input logic [7:0] p,
                            input int l, input bit r);
    exp_t x;
    bit   hit;
    hit = 1'b0;
    if (r) begin
      m_pat = 8'b1001; m_len = 4; hist.delete(); m_busy = 1'b1; m_cnt = 0;
    end else if (ld) begin
      m_pat = p;
      m_len = (l < 2) ? 2 : ((l > 8) ? 8 : l);
      hist.delete(); m_busy = 1'b1; m_cnt = 0;
    end else if (v) begin
      hist.push_back(d);
      if (hist.size() > 8) void'(hist.pop_front());
      if (hist.size() >= m_len) begin
        hit = 1'b1;
        for (int k = 0; k < m_len; k++)
          if (hist[hist.size() - 1 - k] != m_pat[k]) hit = 1'b0;
      end
      if (hit && !overlap) begin
        hist.delete(); m_busy = 1'b1;
      end else if (hist.size() >= m_len) begin
        m_busy = 1'b0;
      end
      if (hit && m_cnt < 3) m_cnt++;
    end
    x.dout = hit;
    x.busy = m_busy;
`ifdef SEQ_DET_CNT_EN
    x.cnt  = 2'(m_cnt);
`else
    x.cnt  = 2'd0;
`endif
    exp_q.push_back(x);
  endtask

  task automatic cycle(input bit d, input bit v, input bit ld, input logic [7:0] p,
                       input logic [3:0] l, input bit r);
    data_in = d; din_vld = v; cfg_load = ld; cfg_pat = p; cfg_len = l; rst = r;
    model_step(d, v, ld, p, int'(l), r);
    @(posedge clk); #1;
    rst = 1'b0; din_vld = 1'b0; cfg_load = 1'b0; data_in = 1'b0;
  endtask

  function automatic exp_t observed();
    exp_t x;
    x.dout = data_out;
    x.busy = busy;
`ifdef SEQ_DET_CNT_EN
    x.cnt  = match_cnt;
`else
    x.cnt  = 2'd0;
`endif
    return x;
  endfunction

  task automatic reset_dut();
    cycle(1'b0, 1'b0, 1'b0, 8'h0, 4'h0, 1'b1);
    void'(exp_q.pop_front());
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 8'h0, 4'h0, (i == 0));
      e = exp_q.pop_front(); o = observed(); n_checks++;
      if (o !== e || o !== exp_t'({1'b0, 1'b1, 2'd0}))
        $display("FAIL reset cyc%0d got dout=%b busy=%b cnt=%0d exp dout=0 busy=1 cnt=0",
                 i, o.dout, o.busy, o.cnt);
      else n_pass++;
    end
  endtask

  task automatic test_no_overlap();
    bit s[$];
    int np;
    bit at9;
    s = '{1,0,0,0,0,1,0,0,1,1,0,0,1};
    reset_dut(); overlap = 1'b0; np = 0; at9 = 1'b0;
    foreach (s[i]) begin
      cycle(s[i], 1'b1, 1'b0, 8'h0, 4'h0, 1'b0);
      e = exp_q.pop_front(); o = observed(); n_checks++;
      if (o !== e)
        $display("FAIL no_overlap bit%0d got dout=%b busy=%b exp dout=%b busy=%b",
                 i + 1, o.dout, o.busy, e.dout, e.busy);
      else n_pass++;
      np += int'(o.dout);
      if (i == 8) at9 = o.dout;
    end
    n_checks++;
    if (at9 !== 1'b1) $display("FAIL no_overlap_bit9 got %b exp 1", at9);
    else n_pass++;
    n_checks++;
    if (np !== 2) $display("FAIL no_overlap_count got %0d exp 2", np);
    else n_pass++;
  endtask

  task automatic test_overlap_mode();
    bit s[$];
    int np;
    s = '{1,0,0,1,0,0,1};
    for (int m = 1; m >= 0; m--) begin
      reset_dut(); overlap = (m == 1); np = 0;
      foreach (s[i]) begin
        cycle(s[i], 1'b1, 1'b0, 8'h0, 4'h0, 1'b0);
        e = exp_q.pop_front(); o = observed(); n_checks++;
        if (o !== e)
          $display("FAIL overlap%0d bit%0d got dout=%b busy=%b exp dout=%b busy=%b",
                   m, i + 1, o.dout, o.busy, e.dout, e.busy);
        else n_pass++;
        np += int'(o.dout);
      end
      n_checks++;
      if (np !== ((m == 1) ? 2 : 1))
        $display("FAIL overlap%0d_count got %0d exp %0d", m, np, (m == 1) ? 2 : 1);
      else n_pass++;
    end
  endtask

  task automatic test_cfg_load();
    bit s[$];
    int np;
    reset_dut(); overlap = 1'b1; np = 0;
    s = '{1,0,0};
    foreach (s[i]) begin
      cycle(s[i], 1'b1, 1'b0, 8'h0, 4'h0, 1'b0);
      void'(exp_q.pop_front());
    end
    cycle(1'b1, 1'b1, 1'b1, 8'b110, 4'd3, 1'b0);
    e = exp_q.pop_front(); o = observed(); n_checks++;
    if (o !== e) $display("FAIL load_cycle got dout=%b busy=%b exp dout=%b busy=%b",
                          o.dout, o.busy, e.dout, e.busy);
    else n_pass++;
    s = '{1,1,0,1,1,0};
    foreach (s[i]) begin
      cycle(s[i], 1'b1, 1'b0, 8'h0, 4'h0, 1'b0);
      e = exp_q.pop_front(); o = observed(); n_checks++;
      if (o !== e)
        $display("FAIL load_110 bit%0d got dout=%b busy=%b exp dout=%b busy=%b",
                 i + 1, o.dout, o.busy, e.dout, e.busy);
      else n_pass++;
      np += int'(o.dout);
    end
    n_checks++;
    if (np !== 2) $display("FAIL load_110_count got %0d exp 2", np);
    else n_pass++;
  endtask

  task automatic test_len_clamp();
    bit s[$];
    int np;
    overlap = 1'b1;
    for (int c = 0; c < 2; c++) begin
      np = 0;
      if (c == 0) begin
        cycle(1'b0, 1'b0, 1'b1, 8'b01, 4'd0, 1'b0);
        s = '{1,0,1};
      end else begin
        cycle(1'b0, 1'b0, 1'b1, 8'hA5, 4'd15, 1'b0);
        s = '{1,0,1,0,0,1,0,1};
      end
      void'(exp_q.pop_front());
      foreach (s[i]) begin
        cycle(s[i], 1'b1, 1'b0, 8'h0, 4'h0, 1'b0);
        e = exp_q.pop_front(); o = observed(); n_checks++;
        if (o !== e)
          $display("FAIL clamp%0d bit%0d got dout=%b busy=%b exp dout=%b busy=%b",
                   c, i + 1, o.dout, o.busy, e.dout, e.busy);
        else n_pass++;
        np += int'(o.dout);
      end
      n_checks++;
      if (np !== 1) $display("FAIL clamp%0d_count got %0d exp 1", c, np);
      else n_pass++;
    end
  endtask

  task automatic test_din_gaps();
    bit s[$];
    int np;
    int gap;
    s = '{1,0,0,1};
    reset_dut(); overlap = 1'b0; np = 0;
    foreach (s[i]) begin
      gap = int'($urandom_range(1, 3));
      for (int g = 0; g < gap; g++) begin
        cycle(~s[i], 1'b0, 1'b0, 8'h0, 4'h0, 1'b0);
        e = exp_q.pop_front(); o = observed(); n_checks++;
        if (o !== e || o.dout !== 1'b0)
          $display("FAIL gap_idle bit%0d got dout=%b busy=%b exp dout=0 busy=%b",
                   i + 1, o.dout, o.busy, e.busy);
        else n_pass++;
        np += int'(o.dout);
      end
      cycle(s[i], 1'b1, 1'b0, 8'h0, 4'h0, 1'b0);
      e = exp_q.pop_front(); o = observed(); n_checks++;
      if (o !== e)
        $display("FAIL gap_bit%0d got dout=%b busy=%b exp dout=%b busy=%b",
                 i + 1, o.dout, o.busy, e.dout, e.busy);
      else n_pass++;
      np += int'(o.dout);
    end
    n_checks++;
    if (np !== 1) $display("FAIL gap_count got %0d exp 1", np);
    else n_pass++;
  endtask

  task automatic test_rst_mid();
    bit s[$];
    int np;
    reset_dut(); overlap = 1'b0;
    s = '{1,0,0};
    foreach (s[i]) begin
      cycle(s[i], 1'b1, 1'b0, 8'h0, 4'h0, 1'b0);
      void'(exp_q.pop_front());
    end
    cycle(1'b1, 1'b1, 1'b0, 8'h0, 4'h0, 1'b1);
    e = exp_q.pop_front(); o = observed(); n_checks++;
    if (o !== e || o.dout !== 1'b0 || o.busy !== 1'b1)
      $display("FAIL rst_mid got dout=%b busy=%b exp dout=0 busy=1", o.dout, o.busy);
    else n_pass++;
    np = 0;
    s = '{1,0,0,1};
    foreach (s[i]) begin
      cycle(s[i], 1'b1, 1'b0, 8'h0, 4'h0, 1'b0);
      e = exp_q.pop_front(); o = observed(); n_checks++;
      if (o !== e)
        $display("FAIL rst_defaults bit%0d got dout=%b busy=%b exp dout=%b busy=%b",
                 i + 1, o.dout, o.busy, e.dout, e.busy);
      else n_pass++;
      np += int'(o.dout);
    end
    n_checks++;
    if (np !== 1) $display("FAIL rst_defaults_count got %0d exp 1", np);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int np;
    reset_dut(); overlap = 1'b1; np = 0;
    cycle(1'b0, 1'b0, 1'b1, 8'b11, 4'd2, 1'b0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 8'h0, 4'h0, 1'b0);
      e = exp_q.pop_front(); o = observed(); n_checks++;
      if (o !== e)
        $display("FAIL b2b bit%0d got dout=%b busy=%b cnt=%0d exp dout=%b busy=%b cnt=%0d",
                 i + 1, o.dout, o.busy, o.cnt, e.dout, e.busy, e.cnt);
      else n_pass++;
      np += int'(o.dout);
    end
    n_checks++;
    if (np !== 5) $display("FAIL b2b_count got %0d exp 5", np);
    else n_pass++;
`ifdef SEQ_DET_CNT_EN
    n_checks++;
    if (match_cnt !== 2'd3) $display("FAIL cnt_sat got %0d exp 3", match_cnt);
    else n_pass++;
    cycle(1'b0, 1'b0, 1'b1, 8'b11, 4'd2, 1'b0);
    e = exp_q.pop_front(); o = observed(); n_checks++;
    if (o !== e || match_cnt !== 2'd0)
      $display("FAIL cnt_load_clear got %0d exp 0", match_cnt);
    else n_pass++;
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_no_overlap();
    test_overlap_mode();
    test_cfg_load();
    test_len_clamp();
    test_din_gaps();
    test_rst_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
